// File: rtl/tile_grid_renderer.sv
// rtl/tile_grid_renderer.sv - tile-grid display engine: cell RAM, map loader, write arbiter, render pipeline
//
// Owns a ROWS x COLS cell RAM. After reset, or when init_start is pulsed, it loads the RAM
// from a combinational map-row source. It then renders cells as tile-ROM pixels into a
// 3-bit {b,g,r} stream. The latency from hpos/vpos to rgb is 2 clocks, so the instantiator
// must delay hsync/vsync by 2 clocks to match.
//
// Ports:
//   clk, reset (async, active-low)          pixel clock / reset
//   hpos, vpos, display_on                  beam position from the hvsync generator
//   map_row_addr -> / map_row_bits <-       map source; bit COLS-1-col is cell col
//   init_start, init_busy, init_done        grid (re)load control and status
//   wr_req, wr_x, wr_y, wr_data, wr_ack     game-logic cell writes, committed only in blanking
//   tile_type, tile_rot, tile_yofs,
//   tile_xofs -> / tile_bit <-              tile-ROM lookup
//   rgb                                     pixel colour
//
// Optional feature macro: TILE_GRID_ROTATION_EN. When it is defined, each cell supplies its
// own tile_rot from bits TILE_BITS+1:TILE_BITS. When it is undefined, tile_rot is tied to 0.
module tile_grid_renderer #(
    parameter int         COLS       = 32,
    parameter int         ROWS       = 32,
    parameter int         TILE_SHIFT = 4,
    parameter int         TILE_BITS  = 2,
    parameter int         CELL_W     = 8,
    parameter logic [2:0] FG_DEFAULT = 3'b100,
    localparam int        CB         = $clog2(COLS),
    localparam int        RB         = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic                 display_on,
    output logic [RB-1:0]        map_row_addr,
    input  logic [COLS-1:0]      map_row_bits,
    input  logic                 init_start,
    output logic                 init_busy,
    output logic                 init_done,
    input  logic                 wr_req,
    input  logic [CB-1:0]        wr_x,
    input  logic [RB-1:0]        wr_y,
    input  logic [CELL_W-1:0]    wr_data,
    output logic                 wr_ack,
    output logic [TILE_BITS-1:0] tile_type,
    output logic [1:0]           tile_rot,
    output logic [2:0]           tile_yofs,
    output logic [2:0]           tile_xofs,
    input  logic                 tile_bit,
    output logic [2:0]           rgb
);

    localparam int             AW        = RB + CB;
    localparam int             NCELLS    = ROWS * COLS;
    localparam logic [AW-1:0]  LAST_CELL = AW'(NCELLS - 1);
    localparam logic [10:0]    H_LIMIT   = 11'(COLS << TILE_SHIFT);
    localparam logic [10:0]    V_LIMIT   = 11'(ROWS << TILE_SHIFT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ld_cnt_q, ld_cnt_d;
    logic [RB-1:0] ld_row;
    logic [CB-1:0] ld_col;

    // Row-major sweep: the column is in the low bits, so it advances fastest.
    assign {ld_row, ld_col} = ld_cnt_q;

    // Stage 0: cell address and flags derived from the beam position.
    logic [CB-1:0] rd_col;
    logic [RB-1:0] rd_row;
    logic          in_grid;

    assign rd_col  = CB'(hpos >> TILE_SHIFT);
    assign rd_row  = RB'(vpos >> TILE_SHIFT);
    // Compare the full position so that out-of-grid pixels never alias onto a wrapped cell.
    assign in_grid = ({1'b0, hpos} < H_LIMIT) && ({1'b0, vpos} < V_LIMIT);

    // Single-port cell RAM.
    logic [CELL_W-1:0] mem [NCELLS];
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [CELL_W-1:0] mem_wdata;
    logic [CELL_W-1:0] ram_dout_d, ram_dout_q;
    logic              wr_grant;

    // Game-logic writes may take the port only during blanking.
    assign wr_grant = (state_q == ST_RUN) && !display_on && wr_req;

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        mem_we    = 1'b0;
        mem_addr  = {rd_row, rd_col};
        mem_wdata = wr_data;
        case (state_q)
            ST_IDLE: begin
                state_d  = ST_LOAD;
                ld_cnt_d = '0;
            end
            ST_LOAD: begin
                mem_we    = 1'b1;
                mem_addr  = ld_cnt_q;
                mem_wdata = {{(CELL_W-1){1'b0}}, map_row_bits[CB'(COLS-1) - ld_col]};
                // The counter wraps to 0 on the last cell, leaving map_row_addr at 0 in RUN.
                ld_cnt_d  = ld_cnt_q + AW'(1);
                if (ld_cnt_q == LAST_CELL) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_grant) begin
                    mem_we   = 1'b1;
                    mem_addr = {wr_y, wr_x};
                end
                if (init_start) begin
                    state_d  = ST_LOAD;
                    ld_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ram_dout_d = mem[mem_addr];
    end

    // RAM contents and read data carry no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        ram_dout_q <= ram_dout_d;
    end

    // Stage 1 registers: flags and tile offsets aligned with the RAM read data.
    logic       s1_run_q, s1_run_d;
    logic       s1_disp_q, s1_disp_d;
    logic       s1_in_q, s1_in_d;
    logic [2:0] s1_xofs_q, s1_xofs_d;
    logic [2:0] s1_yofs_q, s1_yofs_d;
    logic [2:0] rgb_q, rgb_d;
    logic [2:0] fg_field, fg;

    assign fg_field = ram_dout_q[CELL_W-1 -: 3];
    assign fg       = (fg_field == 3'b000) ? FG_DEFAULT : fg_field;

    always_comb begin
        s1_run_d  = (state_q == ST_RUN);
        s1_disp_d = display_on;
        s1_in_d   = in_grid;
        s1_xofs_d = hpos[TILE_SHIFT-1 -: 3];
        s1_yofs_d = vpos[TILE_SHIFT-1 -: 3];
        // Gating on the next state keeps rgb dark from the first LOAD cycle onward.
        rgb_d     = 3'b000;
        if ((state_d == ST_RUN) && s1_run_q && s1_disp_q && s1_in_q && tile_bit) begin
            rgb_d = fg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ld_cnt_q  <= '0;
            s1_run_q  <= 1'b0;
            s1_disp_q <= 1'b0;
            s1_in_q   <= 1'b0;
            s1_xofs_q <= 3'b000;
            s1_yofs_q <= 3'b000;
            rgb_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            s1_run_q  <= s1_run_d;
            s1_disp_q <= s1_disp_d;
            s1_in_q   <= s1_in_d;
            s1_xofs_q <= s1_xofs_d;
            s1_yofs_q <= s1_yofs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign init_busy    = (state_q == ST_LOAD);
    assign init_done    = (state_q == ST_RUN);
    assign wr_ack       = wr_grant;
    assign map_row_addr = ld_row;
    // RAM read data is undefined out of reset, so tile outputs are masked until rendering.
    assign tile_type    = s1_run_q ? ram_dout_q[TILE_BITS-1:0] : '0;
    assign tile_xofs    = s1_xofs_q;
    assign tile_yofs    = s1_yofs_q;
    assign rgb          = rgb_q;

`ifdef TILE_GRID_ROTATION_EN
    assign tile_rot = s1_run_q ? ram_dout_q[TILE_BITS+1:TILE_BITS] : 2'b00;
`else
    assign tile_rot = 2'b00;
`endif

    // Some position and cell bits do not feed any logic in every configuration.
    logic unused_bits;
    assign unused_bits = ^{hpos, vpos, ram_dout_q};

endmodule

// File: tb/tb_tile_grid_renderer.sv
// tb/tb_tile_grid_renderer.sv - scoreboard testbench for tile_grid_renderer
module tb_tile_grid_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       display_on;
    logic [4:0] map_row_addr;
    logic [31:0] map_row_bits;
    logic       init_start, init_busy, init_done;
    logic       wr_req;
    logic [4:0] wr_x, wr_y;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic [1:0] tile_type, tile_rot;
    logic [2:0] tile_yofs, tile_xofs;
    logic       tile_bit;
    logic [2:0] rgb;

    tile_grid_renderer dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .map_row_addr(map_row_addr), .map_row_bits(map_row_bits),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
        .tile_type(tile_type), .tile_rot(tile_rot), .tile_yofs(tile_yofs),
        .tile_xofs(tile_xofs), .tile_bit(tile_bit), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Map source: row r holds 32'hA5A5_0000 ^ r.
    assign map_row_bits = 32'hA5A5_0000 ^ {27'd0, map_row_addr};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_TYPE = 0, K_RGB = 1, K_ACK = 2, K_XOFS = 3, K_YOFS = 4,
                   K_ZERO = 5, K_DONE = 6, K_BUSY = 7, K_VAL = 8;

    typedef struct {
        int    due;
        int    kind;
        int    act;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int mon_act;

    function automatic int zero_vec();
        return 32'({init_busy, init_done, wr_ack, rgb, tile_type, tile_rot,
                    tile_xofs, tile_yofs, map_row_addr});
    endfunction

    function automatic int sample(input int kind, input int act);
        case (kind)
            K_TYPE:  return 32'(tile_type);
            K_RGB:   return 32'(rgb);
            K_ACK:   return 32'(wr_ack);
            K_XOFS:  return 32'(tile_xofs);
            K_YOFS:  return 32'(tile_yofs);
            K_ZERO:  return zero_vec();
            K_DONE:  return 32'(init_done);
            K_BUSY:  return 32'(init_busy);
            default: return act;
        endcase
    endfunction

    // Monitor: compares every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].due <= cyc) begin
                mon_act = sample(sb[i].kind, sb[i].act);
                checks++;
                if (mon_act != sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                             sb[i].name, mon_act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic check_now(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int due, input int kind, input int exp, input string name);
        exp_t e;
        e.due = due; e.kind = kind; e.act = 0; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_val(input string name, input int act, input int exp);
        exp_t e;
        e.due = cyc; e.kind = K_VAL; e.act = act; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    // Hold one pixel for 3 clocks; tile_type is due 1 clock later and rgb 2 clocks later.
    task automatic pixel(input int h, input int v, input logic disp, input logic tbit,
                         input int et, input int er, input string nm);
        @(posedge clk); #1;
        hpos = 10'(h); vpos = 10'(v); display_on = disp; tile_bit = tbit;
        if (et >= 0) push(cyc + 1, K_TYPE, et, {nm, ".type"});
        push(cyc + 1, K_XOFS, (h >> 1) & 7, {nm, ".xofs"});
        push(cyc + 1, K_YOFS, (v >> 1) & 7, {nm, ".yofs"});
        push(cyc + 2, K_RGB, er, {nm, ".rgb"});
        repeat (3) @(posedge clk);
    endtask

    task automatic wr_cell(input int x, input int y, input int d);
        @(posedge clk); #1;
        display_on = 1'b0; wr_x = 5'(x); wr_y = 5'(y); wr_data = 8'(d); wr_req = 1'b1;
        push(cyc, K_ACK, 1, "wr_cell.ack");
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    // Count negedges with init_busy high until init_done. The count is bounded, optionally
    // aborted at abort_at, and can pulse init_start at pulse_at.
    task automatic measure(input int abort_at, input int pulse_at, output int busy);
        busy = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (init_done) break;
            if (init_busy) busy++;
            init_start = (pulse_at != 0) && (busy == pulse_at);
            if (abort_at != 0 && busy == abort_at) break;
        end
        init_start = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        reset = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0; init_start = 1'b0;
        wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; tile_bit = 1'b0;

        repeat (3) @(posedge clk); #1;
        push(cyc, K_ZERO, 0, "reset_outputs");
        check_now("reset_outputs_now", zero_vec(), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        measure(0, 0, busy_cnt);
        push_val("load_cycles", busy_cnt, 1024);
        push_val("load_done", 32'(init_done), 1);

        pixel(5,   55, 1'b1, 1'b1, 1, 3'b100, "r3c0");
        pixel(21,  55, 1'b1, 1'b1, 0, 3'b100, "r3c1");
        pixel(480, 32, 1'b1, 1'b1, 1, 3'b100, "r2c30");
        pixel(496, 32, 1'b1, 1'b1, 0, 3'b100, "r2c31");
        pixel(496, 48, 1'b1, 1'b1, 1, 3'b100, "r3c31");

        wr_cell(0, 0, 8'b0100_0001);
        pixel(0, 0, 1'b1, 1'b1, 1, 3'b010, "c00_fg");
        pixel(0, 0, 1'b1, 1'b0, 1, 3'b000, "c00_bit0");

        // A write request that is held while the display is active must wait for blanking.
        @(posedge clk); #1;
        display_on = 1'b1; hpos = 10'd100; vpos = 10'd100;
        wr_x = 5'd5; wr_y = 5'd2; wr_data = 8'h21; wr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(cyc, K_ACK, 0, "ack_blocked");
            check_now("ack_blocked_now", 32'(wr_ack), 0);
            @(posedge clk); #1;
        end
        display_on = 1'b0;
        push(cyc, K_ACK, 1, "ack_blank");
        @(posedge clk); #1;
        wr_req = 1'b0;

        pixel(83,  34,  1'b1, 1'b1, 1,  3'b001, "r2c5");
        pixel(600, 10,  1'b1, 1'b1, -1, 3'b000, "out_h");
        pixel(100, 600, 1'b1, 1'b1, -1, 3'b000, "out_v");
        pixel(100, 10,  1'b0, 1'b1, -1, 3'b000, "blanked");

        // Restart from RUN, then reset at cell 300 of the sweep.
        @(posedge clk); #1;
        init_start = 1'b1;
        push(cyc + 1, K_DONE, 0, "restart_done_drop");
        push(cyc + 1, K_BUSY, 1, "restart_busy");
        @(posedge clk); #1;
        init_start = 1'b0;
        measure(300, 0, busy_cnt);
        #1;
        reset = 1'b0;
        #1;
        push_val("async_reset_zero", zero_vec(), 0);
        check_now("async_reset_zero_now", zero_vec(), 0);
        push(cyc, K_ZERO, 0, "reset_hold_zero");
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;

        measure(0, 500, busy_cnt);
        push_val("reload_cycles", busy_cnt, 1024);
        push_val("reload_done", 32'(init_done), 1);
        pixel(0, 0, 1'b1, 1'b1, 1, 3'b100, "reload_c00");

        repeat (4) @(posedge clk); #1;
        push_val("scoreboard_drained", sb.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tile_grid_renderer.md
Name: tile_grid_renderer

Overview:
- Parametrised tile-grid display engine: owns the cell RAM, loads it from a map-row source on start-up, and renders cells as tile-ROM pixels into an RGB stream for the hvsync timing chain.
- Adds three things over the fixed 32x32 single-colour display:
  - configurable grid, tile and cell sizes;
  - a runtime write port for game logic, arbitrated into blanking;
  - per-cell foreground colour.

Parameters:
- COLS, 32: grid columns; power of two, with (COLS << TILE_SHIFT) <= 1024.
- ROWS, 32: grid rows; power of two, with (ROWS << TILE_SHIFT) <= 1024.
- TILE_SHIFT, 4: log2 of the on-screen tile size in pixels; must be >= 3. Each tile is 8x8 ROM pixels, scaled by 2^(TILE_SHIFT-3).
- TILE_BITS, 2: width of the tile-type field, cell[TILE_BITS-1:0].
- CELL_W, 8: cell RAM word width; must be >= TILE_BITS+5.
- FG_DEFAULT, 3'b100: foreground colour used when cell[CELL_W-1:CELL_W-3] == 0.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- hpos  in  10  horizontal pixel position from the hvsync generator.
- vpos  in  10  vertical pixel position.
- display_on  in  1  visible-area flag, aligned with hpos/vpos.
- map_row_addr  out  log2(ROWS)  row index presented to the map source.
- map_row_bits  in  COLS  combinational map row; bit COLS-1-col is cell col.
- init_start  in  1  pulse: (re)load the grid from the map.
- init_busy  out  1  load sweep in progress.
- init_done  out  1  grid valid; rendering enabled.
- wr_req  in  1  game-logic cell write request; held high until wr_ack.
- wr_x  in  log2(COLS)  write column.
- wr_y  in  log2(ROWS)  write row.
- wr_data  in  CELL_W  write data.
- wr_ack  out  1  one-cycle pulse on the cycle the write is committed.
- tile_type  out  TILE_BITS  tile-ROM select.
- tile_rot  out  2  tile-ROM rotation.
- tile_yofs  out  3  tile-ROM scanline.
- tile_xofs  out  3  tile-ROM pixel.
- tile_bit  in  1  combinational tile-ROM output.
- rgb  out  3  pixel colour as {b,g,r}.

Behaviour:
- Reset (asynchronous, while reset==0):
  - state=IDLE; rgb, init_busy, init_done, wr_ack, tile_* and map_row_addr are all 0.
  - Pipeline registers are cleared.
  - RAM contents are undefined.
- FSM IDLE:
  - On the first clock after reset deasserts, or on init_start, go to LOAD and clear the sweep counters.
- FSM LOAD:
  - Writes one cell per clock in row-major order, col fastest.
  - map_row_addr = current row.
  - Written word = {(CELL_W-1)'b0, map_row_bits[COLS-1-col]}.
  - init_busy=1 and rgb=0 throughout.
  - After cell (ROWS-1, COLS-1) is written, go to RUN. Total time is exactly ROWS*COLS cycles with init_busy high.
  - init_start during LOAD is ignored.
  - wr_req during LOAD is not acked; the request stays pending.
- FSM RUN:
  - init_done=1.
  - init_start: go to LOAD and drop init_done on the next clock.
- RAM port arbitration in RUN (single port):
  - When display_on==1, the port belongs to the renderer.
  - When display_on==0 and wr_req==1, the cell at {wr_y,wr_x} is written with wr_data and wr_ack pulses in that same cycle.
  - For back-to-back requests, at most one write is committed per clock.
- Render pipeline in RUN (latency 2 clocks, hpos to rgb):
  - Stage 0: row = vpos >> TILE_SHIFT and col = hpos >> TILE_SHIFT (truncated to their widths); RAM read address = {row,col}. The in-grid flag, display_on, xofs = hpos[TILE_SHIFT-1 -: 3] and yofs = vpos[TILE_SHIFT-1 -: 3] are registered.
  - Stage 1: RAM dout is valid. tile_type = cell[TILE_BITS-1:0]; tile_xofs/tile_yofs carry the registered offsets. The foreground colour (cell[CELL_W-1:CELL_W-3], or FG_DEFAULT if that field is 0) is registered with the delayed flags.
  - Stage 2: rgb <= (delayed display_on && in-grid && tile_bit) ? fg : 3'b000.
- Out-of-grid pixels (hpos >= COLS<<TILE_SHIFT or vpos >= ROWS<<TILE_SHIFT) render 0. Their address is don't-care and must not wrap visibly.
- Downstream hsync/vsync must be delayed 2 clocks by the instantiator.
- Reset mid-LOAD: the sweep aborts immediately and the partially loaded RAM is reloaded in full after reset release.

Optional Feature:
- Macro TILE_GRID_ROTATION_EN.
- Defined: tile_rot = cell[TILE_BITS+1:TILE_BITS] at stage 1, so a rotation field lives in each cell; CELL_W must be >= TILE_BITS+5.
- Undefined: tile_rot is tied to 2'b00 and cell bits TILE_BITS+1:TILE_BITS are ignored.

Test Plan:
- Defaults, map row r = 32'hA5A5_0000 ^ r; release reset -> init_busy high exactly 1024 cycles, then init_done=1. Backdoor check: cell(3,0) LSB = bit 31 of row 3's value, i.e. 1.
- RUN, cell(0,0)=8'b0100_0001, tile_bit forced 1, hpos=0/vpos=0 with display_on=1 -> tile_type=1 one clock later; rgb=3'b010 two clocks later.
- Cell colour field 0 -> rgb=FG_DEFAULT (3'b100) on tile_bit=1; tile_bit=0 -> rgb=0.
- wr_req with wr_x=5, wr_y=2, wr_data=8'h21 while display_on=1 for 20 cycles -> no wr_ack. Then display_on falls -> wr_ack the same cycle; later render of (row 2, col 5) gives tile_type=1 and rgb=3'b001.
- hpos=600 (>= 512) with display_on=1 -> rgb=0 regardless of tile_bit.
- Assert reset at cell 300 of the LOAD sweep -> all outputs 0 asynchronously; after release init_busy lasts a full 1024 cycles. init_start pulsed mid-LOAD -> no extension.
